// File: rtl/instr_realign_expand_pkg.sv
// Shared RVC decode constants, expansion result type and 32-bit encoders for
// the instruction realigner.
package instr_realign_expand_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP   = 7'h07;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_STORE_FP  = 7'h27;
  localparam logic [6:0] OPC_OP        = 7'h33;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;

  localparam logic [2:0] C0_ADDI4SPN   = 3'b000;
  localparam logic [2:0] C0_FLD        = 3'b001;
  localparam logic [2:0] C0_LW         = 3'b010;
  localparam logic [2:0] C0_LD_FLW     = 3'b011;
  localparam logic [2:0] C0_FSD        = 3'b101;
  localparam logic [2:0] C0_SW         = 3'b110;
  localparam logic [2:0] C0_SD_FSW     = 3'b111;

  localparam logic [2:0] C1_ADDI       = 3'b000;
  localparam logic [2:0] C1_ADDIW_JAL  = 3'b001;
  localparam logic [2:0] C1_LI         = 3'b010;
  localparam logic [2:0] C1_LUI        = 3'b011;
  localparam logic [2:0] C1_MISC_ALU   = 3'b100;
  localparam logic [2:0] C1_J          = 3'b101;
  localparam logic [2:0] C1_BEQZ       = 3'b110;
  localparam logic [2:0] C1_BNEZ       = 3'b111;

  localparam logic [2:0] C2_SLLI       = 3'b000;
  localparam logic [2:0] C2_FLDSP      = 3'b001;
  localparam logic [2:0] C2_LWSP       = 3'b010;
  localparam logic [2:0] C2_LDSP_FLWSP = 3'b011;
  localparam logic [2:0] C2_JR_MV      = 3'b100;
  localparam logic [2:0] C2_FSDSP      = 3'b101;
  localparam logic [2:0] C2_SWSP       = 3'b110;
  localparam logic [2:0] C2_SDSP_FSWSP = 3'b111;

  typedef struct packed {
    logic [31:0] instr;
    logic        is_compressed;
    logic        illegal;
  } rvc_result_t;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

endpackage

// File: rtl/instr_realign_expand_rvc_expand.sv
// Combinational RVC-to-32-bit expander. Define RVC_FP_EN to expand the
// compressed floating-point loads/stores; otherwise they decode as illegal.
module rvc_expand
  import instr_realign_expand_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]  instr_i,
  output rvc_result_t  result_o
);

  localparam bit RV64 = (XLEN == 64);
`ifdef RVC_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
  logic [5:0]  shamt;
  logic [11:0] imm6s, addi4, lw_u, ld_u, lwsp_u, ldsp_u, swsp_u, sdsp_u, sp16;
  logic [19:0] lui_imm;
  logic [20:0] jimm;
  logic [12:0] bimm;
  logic [31:0] out;
  logic        ill;

  always_comb begin
    c       = instr_i[15:0];
    rd      = c[11:7];
    rs2     = c[6:2];
    rdp     = {2'b01, c[4:2]};
    rs1p    = {2'b01, c[9:7]};
    rs2p    = {2'b01, c[4:2]};
    shamt   = {c[12], c[6:2]};
    imm6s   = {{7{c[12]}}, c[6:2]};
    addi4   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
    lw_u    = {5'b0, c[5], c[12:10], c[6], 2'b00};
    ld_u    = {4'b0, c[6:5], c[12:10], 3'b000};
    lwsp_u  = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    ldsp_u  = {3'b0, c[4:2], c[12], c[6:5], 3'b000};
    swsp_u  = {4'b0, c[8:7], c[12:9], 2'b00};
    sdsp_u  = {3'b0, c[9:7], c[12:10], 3'b000};
    sp16    = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    lui_imm = {{15{c[12]}}, c[6:2]};
    jimm    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    bimm    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    out     = '0;
    ill     = 1'b0;

    case (c[1:0])
      RVC_Q0: begin
        case (c[15:13])
          C0_ADDI4SPN: begin
            out = enc_i(addi4, 5'd2, 3'b000, rdp, OPC_OP_IMM);
            ill = (addi4 == '0);
          end
          C0_FLD: begin
            out = enc_i(ld_u, rs1p, 3'b011, rdp, OPC_LOAD_FP);
            ill = !FP_EN;
          end
          C0_LW: out = enc_i(lw_u, rs1p, 3'b010, rdp, OPC_LOAD);
          C0_LD_FLW: begin
            if (RV64) out = enc_i(ld_u, rs1p, 3'b011, rdp, OPC_LOAD);
            else begin
              out = enc_i(lw_u, rs1p, 3'b010, rdp, OPC_LOAD_FP);
              ill = !FP_EN;
            end
          end
          C0_FSD: begin
            out = enc_s(ld_u, rs2p, rs1p, 3'b011, OPC_STORE_FP);
            ill = !FP_EN;
          end
          C0_SW: out = enc_s(lw_u, rs2p, rs1p, 3'b010, OPC_STORE);
          C0_SD_FSW: begin
            if (RV64) out = enc_s(ld_u, rs2p, rs1p, 3'b011, OPC_STORE);
            else begin
              out = enc_s(lw_u, rs2p, rs1p, 3'b010, OPC_STORE_FP);
              ill = !FP_EN;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      RVC_Q1: begin
        case (c[15:13])
          C1_ADDI: out = enc_i(imm6s, rd, 3'b000, rd, OPC_OP_IMM);
          C1_ADDIW_JAL: begin
            if (RV64) begin
              out = enc_i(imm6s, rd, 3'b000, rd, OPC_OP_IMM_32);
              ill = (rd == '0);
            end else begin
              out = enc_j(jimm, 5'd1);
            end
          end
          C1_LI: out = enc_i(imm6s, 5'd0, 3'b000, rd, OPC_OP_IMM);
          C1_LUI: begin
            // rd=x2 selects c.addi16sp; every other rd is c.lui
            if (rd == 5'd2) begin
              out = enc_i(sp16, 5'd2, 3'b000, 5'd2, OPC_OP_IMM);
              ill = (sp16 == '0);
            end else begin
              out = {lui_imm, rd, OPC_LUI};
              ill = (shamt == '0);
            end
          end
          C1_MISC_ALU: begin
            case (c[11:10])
              2'b00: begin
                out = enc_i({6'b000000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
                ill = !RV64 && c[12];
              end
              2'b01: begin
                out = enc_i({6'b010000, shamt}, rs1p, 3'b101, rs1p, OPC_OP_IMM);
                ill = !RV64 && c[12];
              end
              2'b10: out = enc_i(imm6s, rs1p, 3'b111, rs1p, OPC_OP_IMM);
              default: begin
                if (!c[12]) begin
                  case (c[6:5])
                    2'b00:   out = enc_r(7'b0100000, rs2p, rs1p, 3'b000, rs1p, OPC_OP);
                    2'b01:   out = enc_r(7'b0000000, rs2p, rs1p, 3'b100, rs1p, OPC_OP);
                    2'b10:   out = enc_r(7'b0000000, rs2p, rs1p, 3'b110, rs1p, OPC_OP);
                    default: out = enc_r(7'b0000000, rs2p, rs1p, 3'b111, rs1p, OPC_OP);
                  endcase
                end else if (RV64 && !c[6]) begin
                  out = enc_r(c[5] ? 7'b0000000 : 7'b0100000, rs2p, rs1p, 3'b000, rs1p, OPC_OP_32);
                end else begin
                  ill = 1'b1;
                end
              end
            endcase
          end
          C1_J:    out = enc_j(jimm, 5'd0);
          C1_BEQZ: out = enc_b(bimm, rs1p, 3'b000);
          default: out = enc_b(bimm, rs1p, 3'b001);
        endcase
      end
      RVC_Q2: begin
        case (c[15:13])
          C2_SLLI: begin
            out = enc_i({6'b000000, shamt}, rd, 3'b001, rd, OPC_OP_IMM);
            ill = !RV64 && c[12];
          end
          C2_FLDSP: begin
            out = enc_i(ldsp_u, 5'd2, 3'b011, rd, OPC_LOAD_FP);
            ill = !FP_EN;
          end
          C2_LWSP: begin
            out = enc_i(lwsp_u, 5'd2, 3'b010, rd, OPC_LOAD);
            ill = (rd == '0);
          end
          C2_LDSP_FLWSP: begin
            if (RV64) begin
              out = enc_i(ldsp_u, 5'd2, 3'b011, rd, OPC_LOAD);
              ill = (rd == '0);
            end else begin
              out = enc_i(lwsp_u, 5'd2, 3'b010, rd, OPC_LOAD_FP);
              ill = !FP_EN;
            end
          end
          C2_JR_MV: begin
            if (!c[12]) begin
              if (rs2 == '0) begin
                out = enc_i(12'h000, rd, 3'b000, 5'd0, OPC_JALR);
                ill = (rd == '0);
              end else begin
                out = enc_r(7'b0000000, rs2, 5'd0, 3'b000, rd, OPC_OP);
              end
            end else begin
              if (rs2 == '0) begin
                if (rd == '0) out = INSTR_EBREAK;
                else          out = enc_i(12'h000, rd, 3'b000, 5'd1, OPC_JALR);
              end else begin
                out = enc_r(7'b0000000, rs2, rd, 3'b000, rd, OPC_OP);
              end
            end
          end
          C2_FSDSP: begin
            out = enc_s(sdsp_u, rs2, 5'd2, 3'b011, OPC_STORE_FP);
            ill = !FP_EN;
          end
          C2_SWSP: out = enc_s(swsp_u, rs2, 5'd2, 3'b010, OPC_STORE);
          default: begin
            if (RV64) out = enc_s(sdsp_u, rs2, 5'd2, 3'b011, OPC_STORE);
            else begin
              out = enc_s(swsp_u, rs2, 5'd2, 3'b010, OPC_STORE_FP);
              ill = !FP_EN;
            end
          end
        endcase
      end
      default: out = instr_i;
    endcase

    if (ill) out = {16'h0000, c};

    result_o.instr         = out;
    result_o.is_compressed = (c[1:0] != 2'b11);
    result_o.illegal       = ill;
  end

endmodule

// File: rtl/instr_realign_expand.sv
// Fetch-block realigner: circular 16-bit parcel buffer feeding an RVC expander.
// RVC_FP_EN (see rvc_expand) enables the compressed FP load/store forms.
module instr_realign_expand
  import instr_realign_expand_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 32,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [FETCH_WIDTH-1:0] fetch_data_i,
  input  logic [XLEN-1:0]        fetch_addr_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_o,
  output logic [XLEN-1:0]        pc_o,
  output logic                   is_compressed_o,
  output logic                   illegal_o
);

  localparam int unsigned NP = FETCH_WIDTH / 16;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NP_C    = CW'(NP);

  logic [15:0]     buf_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] head_pc_q;

  logic [15:0]     head_parcel, next_parcel;
  logic            head_is_c, accept, pop;
  logic [CW-1:0]   push_n, pop_n;
  rvc_result_t     exp_res;

  // Pointer advance modulo DEPTH; k never exceeds DEPTH so one wrap suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] k);
    logic [CW:0] s;
    s = (CW+1)'(p) + (CW+1)'(k);
    if (s >= (CW+1)'(DEPTH)) s = s - (CW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  always_comb begin
    head_parcel   = buf_q[head_q];
    next_parcel   = buf_q[ptr_add(head_q, CW'(1))];
    head_is_c     = (head_parcel[1:0] != 2'b11);
    instr_valid_o = (count_q != '0) && (head_is_c || (count_q >= CW'(2)));
    fetch_ready_o = ((DEPTH_C - count_q) >= NP_C);
    accept        = fetch_valid_i && fetch_ready_o && !flush_i;
    pop           = instr_valid_o && instr_ready_i && !flush_i;
    push_n        = accept ? (fetch_addr_i[1] ? NP_C - CW'(1) : NP_C) : '0;
    pop_n         = pop ? (head_is_c ? CW'(1) : CW'(2)) : '0;
  end

  rvc_expand #(.XLEN(XLEN)) u_rvc_expand (
    .instr_i  ({next_parcel, head_parcel}),
    .result_o (exp_res)
  );

  always_comb begin
    instr_o         = instr_valid_o ? exp_res.instr : '0;
    is_compressed_o = instr_valid_o && exp_res.is_compressed;
    illegal_o       = instr_valid_o && exp_res.illegal;
    pc_o            = head_pc_q;
  end

  // A block fetched from an odd halfword skips its first parcel.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (!(fetch_addr_i[1] && (i == 0)))
          buf_q[ptr_add(tail_q, fetch_addr_i[1] ? CW'(i - 1) : CW'(i))] <= fetch_data_i[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= '0;
    end else if (flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      if (accept) tail_q <= ptr_add(tail_q, push_n);
      if (pop) begin
        head_q    <= ptr_add(head_q, pop_n);
        head_pc_q <= head_pc_q + (head_is_c ? XLEN'(2) : XLEN'(4));
      end else if (accept && (count_q == '0)) begin
        head_pc_q <= fetch_addr_i;
      end
      count_q <= count_q + push_n - pop_n;
    end
  end

endmodule

// File: doc/instr_realign_expand.md
INSTR_REALIGN_EXPAND -- requirements
Module: instr_realign_expand

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 32, fetch block width in bits; legal values 32, 64.
REQ-002 SHALL have parameter XLEN, default 64, RV32 (32) or RV64 (64) expansion rules.
REQ-003 SHALL have parameter DEPTH, default 8, parcel buffer depth in 16-bit parcels; must be at least 2*FETCH_WIDTH/16.
REQ-004 SHALL have the following ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset; synchronous and active-high.
- flush_i  in  1  discard all buffered parcels.
- fetch_valid_i  in  1  fetch block present.
- fetch_ready_o  out  1  block accepted this cycle.
- fetch_data_i  in  FETCH_WIDTH  little-endian parcels.
- fetch_addr_i  in  XLEN  byte address of the block (halfword aligned).
- instr_valid_o  out  1  expanded instruction present.
- instr_ready_i  in  1  consumer takes the instruction.
- instr_o  out  32  expanded 32-bit instruction.
- pc_o  out  XLEN  address of the instruction's first parcel.
- is_compressed_o  out  1  the source instruction was 16-bit.
- illegal_o  out  1  the compressed encoding is illegal.

Function
REQ-005 SHALL hold a circular parcel buffer (DEPTH entries) with head/tail pointers wrapping modulo DEPTH, plus an occupancy count and a head-PC register.
REQ-006 SHALL assert fetch_ready_o iff (DEPTH - count) >= FETCH_WIDTH/16, using the registered count only; a same-cycle pop SHALL NOT be credited.
REQ-007 On accept, SHALL push all parcels of the block in ascending address order; if fetch_addr_i[1]=1, SHALL drop parcel 0 and push the rest.
REQ-008 On accept with count=0, SHALL load head-PC from fetch_addr_i.
REQ-009 SHALL classify the head parcel as compressed iff bits[1:0] != 2'b11.
REQ-010 SHALL assert instr_valid_o iff count>=1 for a compressed head, or count>=2 for an uncompressed head; no straddling instruction SHALL be emitted before both halves are buffered.
REQ-011 Outputs SHALL be combinational from buffer registers, giving 1-cycle latency from accept to instr_valid_o.
REQ-012 While instr_valid_o=1 and instr_ready_i=0, all outputs SHALL be held stable.
REQ-013 On handshake, SHALL pop 1 or 2 parcels and advance head-PC by 2 or 4 (XLEN-bit, wrapping).
REQ-014 Simultaneous push and pop SHALL update count by (pushed - popped) in one cycle.
REQ-015 Uncompressed instructions SHALL pass through unchanged with illegal_o=0.
REQ-016 Compressed instructions SHALL expand per the RVC spec for XLEN (C1 funct3=001 is c.addiw on RV64 and c.jal on RV32; rd=0 on c.addiw is illegal).
REQ-017 An illegal compressed instruction SHALL set illegal_o=1 and set instr_o to the parcel zero-extended.
REQ-018 flush_i SHALL zero count and pointers at the next edge, ignore a same-cycle fetch, and give instr_valid_o=0 the next cycle; it has priority over push and pop.

Reset
REQ-019 When rst_i=1 at an edge, SHALL set count, pointers and head-PC to 0.
REQ-020 After reset, SHALL drive instr_valid_o=0 and fetch_ready_o=1, with instr_o, pc_o, is_compressed_o and illegal_o all 0.
REQ-021 Reset during a half-received straddle SHALL discard it entirely.

Configuration
REQ-022 With RVC_FP_EN defined, SHALL expand c.fld, c.fsd, c.fldsp and c.fsdsp, plus c.flw, c.fsw, c.flwsp and c.fswsp on RV32.
REQ-023 Without RVC_FP_EN, those encodings SHALL report illegal_o=1 per REQ-017.

Structure
REQ-024 Shared package SHALL hold the RVC opcode/funct3 constants and a struct {instr, is_compressed, illegal}.
REQ-025 Expansion SHALL be one combinational sub-module rvc_expand (XLEN parameter); the buffer and control stay in the top module.

Verification (FETCH_WIDTH=32, XLEN=64)
REQ-026 Block 0x45014081 at 0x80000000 -> 0x00000093 @0x80000000, then 0x00000513 @0x80000002, is_compressed_o=1 for both.
REQ-027 Block 0x00934081 then 0x45010000 -> 0x00000093 @+0, 0x00000093 @+2 (uncompressed, emitted only after block 2), 0x00000513 @+6.
REQ-028 Block 0x45014081 at 0x80000002 -> only 0x00000513 @0x80000002.
REQ-029 Parcel 0x0000 -> illegal_o=1, instr_o=0x00000000; with parcel 0x2000: RVC_FP_EN gives 0x00043407, no macro gives illegal_o=1 and instr_o=0x00002000.
REQ-030 Buffer filled with instr_ready_i=0 -> fetch_ready_o=0 and outputs stable; then flush_i mid-straddle -> instr_valid_o=0 next cycle and fetch_ready_o=1.
